// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-port data memory slave.
// A request is latched in IDLE, waits LATENCY cycles in BUSY, and completes
// with a one-cycle READY pulse in RESP. Faulted accesses keep the same timing
// but leave storage untouched and report ERR with READY.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic        MEMWRITE,
  input  logic        MEMREAD,
  output logic [31:0] RDATA,
  output logic        READY,
  output logic        STALL,
  output logic        ERR
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_INIT   = 4'(LATENCY);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            is_write_q;
  logic            fault_q;
  logic            accept;
  logic            finish;
  logic            fault_in;
  logic [31:0]     mem [DEPTH_WORDS];

  // Next-state decode plus the accept/finish strobes used by the datapath.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    fault_in   = (ADDR[1:0] != 2'b00) || (ADDR >= BYTE_LIMIT) ||
                 (MEMREAD && MEMWRITE);
    case (state)
      IDLE: begin
        if (MEMREAD || MEMWRITE) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          finish     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins in every state and aborts any access.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture and wait counter; later inputs are ignored until IDLE.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt        <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      is_write_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (accept) begin
      cnt        <= LAT_INIT;
      idx_q      <= ADDR[AW+1:2];
      wdata_q    <= WDATA;
      is_write_q <= MEMWRITE && !MEMREAD;
      fault_q    <= fault_in;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Registered response: READY/ERR pulse for the RESP cycle, RDATA holds.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      READY <= 1'b0;
      ERR   <= 1'b0;
      RDATA <= 32'd0;
    end else begin
      READY <= finish;
      ERR   <= finish && fault_q;
      if (finish) begin
        if (fault_q)          RDATA <= 32'd0;
        else if (!is_write_q) RDATA <= mem[idx_q];
      end
    end
  end

  // Storage array; cleared on reset, written only by a valid store.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      // NOTE: the array is reset element by element because cleared storage
      // is required behaviour; this rules out mapping it onto a block RAM.
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (finish && is_write_q && !fault_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign STALL = (state == BUSY);

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit storage words (power of 2, 4..256).
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles per access (legal range 1..15).
REQ-003 SHALL have port CLOCK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ADDR  input  32  byte address from the CPU.
REQ-006 SHALL have port WDATA  input  32  store data.
REQ-007 SHALL have port MEMWRITE  input  1  write request.
REQ-008 SHALL have port MEMREAD  input  1  read request.
REQ-009 SHALL have port RDATA  output  32  registered load data.
REQ-010 SHALL have port READY  output  1  registered one-cycle access-complete pulse.
REQ-011 SHALL have port STALL  output  1  high while an access is in progress (CPU hold).
REQ-012 SHALL have port ERR  output  1  registered; qualifies READY as a faulted access.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE, a rising edge with MEMREAD or MEMWRITE high SHALL accept a request: latch ADDR, WDATA, and op; load the wait counter with LATENCY; go to BUSY.
REQ-015 Inputs other than RESET SHALL be ignored in BUSY and RESP; latched values alone determine the access.
REQ-016 In BUSY, the counter SHALL decrement each edge; on the edge where the counter equals 1, the FSM SHALL perform the access and go to RESP (BUSY lasts exactly LATENCY cycles).
REQ-017 In RESP, READY SHALL be 1 for exactly one cycle; the next edge SHALL return to IDLE unconditionally (no request accepted in RESP).
REQ-018 A request held continuously SHALL therefore start one new access every LATENCY+2 cycles.
REQ-019 STALL SHALL be 1 exactly in BUSY cycles; 0 in IDLE and RESP.
REQ-020 Word index SHALL be ADDR[log2(DEPTH_WORDS)+1:2].
REQ-021 Fault conditions: ADDR[1:0] != 0; ADDR >= 4*DEPTH_WORDS; MEMREAD and MEMWRITE both high at acceptance.
REQ-022 On a fault, the access SHALL complete with the same timing, with ERR=1 alongside READY; memory SHALL be unchanged; RDATA SHALL be 0.
REQ-023 Valid write: the word SHALL be updated on the BUSY->RESP edge; RDATA SHALL keep its prior value.
REQ-024 Valid read: RDATA SHALL be loaded on the BUSY->RESP edge; RDATA SHALL hold until the next completed read or fault.
REQ-025 ERR SHALL be 0 in every cycle where READY is 0.

Reset
REQ-026 While RESET=1 at an edge, the block SHALL enter IDLE with READY=0, STALL=0, ERR=0, RDATA=0x00000000, counter=0, and all storage words cleared to 0.
REQ-027 RESET SHALL take priority over all other inputs in every state; an in-flight access SHALL be aborted with no write performed and no READY.
REQ-028 The first request SHALL be accepted on the first edge with RESET=0.

Verification (LATENCY=2, DEPTH_WORDS=64)
REQ-029 Write ADDR=0x10, WDATA=0xDEADBEEF accepted at edge k -> STALL=1 in the 2 cycles after edge k; READY=1, ERR=0 in the cycle after edge k+2; STALL=0 then.
REQ-030 Read ADDR=0x10 after REQ-029 -> READY pulse with RDATA=0xDEADBEEF, ERR=0; RDATA still 0xDEADBEEF after read deasserted.
REQ-031 Write ADDR=0x12 (misaligned), then read 0x10 -> first access READY=1, ERR=1, RDATA=0; read returns 0xDEADBEEF.
REQ-032 Read ADDR=0x100 (out of range), then MEMREAD=MEMWRITE=1 at 0x10 -> both accesses ERR=1 with READY; word 0x10 unchanged.
REQ-033 Write 0x20 = 0x12345678; assert RESET in the first BUSY cycle -> no READY; read 0x20 afterwards returns 0x00000000.
REQ-034 MEMREAD held high for 8 cycles from reset release -> READY pulses at cycles 3 and 7 (period LATENCY+2=4).
